rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- It uses the team's 8-bit priority-encode function, applied to a rotated request vector, to select each winner.
- It sits in front of any shared datapath unit. The winner's one-hot grant and 3-bit id drive the unit's input mux select.
- Grants are registered, hand off with no idle bubble, and have an optional hold limit to prevent starvation.

Parameters:
- MAX_HOLD, default 16: maximum consecutive cycles one owner keeps the grant while others are waiting. Legal range 0..255. 0 disables preemption.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i. Level-sensitive; held high for as long as access is wanted.
- grant  output  8  one-hot grant, registered. 8'h00 when the resource is free.
- grant_id  output  3  binary index of the current owner, registered. Valid only when busy=1.
- busy  output  1  high while any grant is active; equals |grant.

Behaviour:
- Reset (rst_n=0): takes effect immediately, with no clock edge needed.
  - grant=8'h00, grant_id=3'h0, busy=0.
  - Internal pointer ptr=3'h7, so requester 0 has top priority first. hold_cnt=0. State=IDLE.
  - Deasserting rst_n takes effect at the next clk edge.
- Winner selection (combinational):
  - Search order is (ptr+1), (ptr+2), ... , (ptr+8), all mod 8.
  - The winner is the first index in that order with its bit set in the search mask.
  - Implementation: rotate the mask right by ptr+1, priority-encode, then add ptr+1 mod 8.
- States: IDLE (no owner) and GRANT (owner = grant_id).
- IDLE:
  - If req != 0 at an edge: load winner with mask=req; grant=1<<winner, grant_id=winner, busy=1, ptr=winner, hold_cnt=0; go to GRANT.
  - Latency is exactly 1 edge from req sampled to grant visible.
  - If req == 0: stay in IDLE with all outputs 0.
- GRANT, release: req[owner]=0 sampled at an edge.
  - If other requests are pending: direct handoff at the same edge to the winner with mask=req. No idle cycle; hold_cnt=0; ptr=new owner.
  - If none are pending: grant=0, busy=0, go to IDLE. ptr keeps the last owner.
- GRANT, hold: req[owner]=1 and no preemption.
  - Grant is unchanged.
  - hold_cnt increments, saturating at MAX_HOLD-1 (or at 0 when MAX_HOLD=0).
- GRANT, preemption: MAX_HOLD>0, hold_cnt==MAX_HOLD-1, and (req & ~grant) != 0.
  - At that edge the grant moves to the winner with mask=req & ~grant.
  - The owner has then held exactly MAX_HOLD cycles. It may re-request and will be served in round-robin order.
- Sole requester: if no other request is pending, the owner keeps the grant indefinitely. hold_cnt stays saturated, and preemption fires on the first edge another request appears.
- Simultaneous release and preemption: release takes precedence; both use the same mask result.
- Requests that rise and fall between edges are not captured. No request latching.
- Invariants:
  - grant is always 0 or one-hot.
  - grant_id == encode(grant) whenever busy=1.
  - No output ever changes except on a clk edge or asynchronous reset.

Test Plan:
- Reset priority: hold rst_n=0 with req=8'hFF -> grant=8'h00, busy=0. Release rst_n -> after 1 edge grant=8'h01, grant_id=0.
- Preemption rotation (MAX_HOLD=4): req=8'h81 held constant -> grant=8'h01 for 4 cycles, then 8'h80 for 4, then 8'h01 again, repeating.
- Bubble-free handoff: owner 2 holds, req=8'h24, then req[2] drops -> next edge grant=8'h20, grant_id=5, busy never 0.
- Wrap-around search: last owner 6 releases with req=8'h03 -> order 7,0,1 gives grant=8'h01. Next release with req=8'h02 -> grant=8'h02.
- Sole requester / disabled limit:
  - req=8'h08 for 40 cycles -> grant=8'h08 throughout.
  - MAX_HOLD=0 with req=8'h09 and owner 3 -> grant stays 8'h08 until req[3] drops.
- Asynchronous reset mid-grant: assert rst_n=0 between edges while grant=8'h10 -> grant=0, busy=0 immediately. After release with req=8'h10 -> grant returns 1 edge later.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered one-hot grant,
// bubble-free handoff and an optional hold limit against starvation.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM =
    (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic PREEMPT_EN = (MAX_HOLD > 0);

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_id_q, grant_id_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [7:0]  mask;
  logic [2:0]  off;
  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  win;
  logic        others;
  logic        owner_req;
  logic        preempt;

  // lowest set bit wins; all-zero input maps to 0
  function automatic logic [2:0] prio_enc8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // winner search: rotate so ptr+1 sits at bit 0, encode, rotate back
  always_comb begin
    mask      = req & ~grant_q;
    off       = ptr_q + 3'd1;
    dbl       = {mask, mask} >> off;
    rot       = dbl[7:0];
    win       = prio_enc8(rot) + off;
    others    = |mask;
    owner_req = req[grant_id_q];
    preempt   = PREEMPT_EN && (hold_cnt_q == HOLD_LIM) && others;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 8'h00;
      grant_id_q <= 3'h0;
      ptr_q      <= 3'h7;
      hold_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // next state: load a new winner, release, or keep holding
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (others) begin
          state_d    = GRANT;
          grant_d    = 8'h01 << win;
          grant_id_d = win;
          ptr_d      = win;
          hold_cnt_d = 8'h00;
        end
      end
      GRANT: begin
        unique case (1'b1)
          (!owner_req && others),
          (owner_req && preempt): begin
            grant_d    = 8'h01 << win;
            grant_id_d = win;
            ptr_d      = win;
            hold_cnt_d = 8'h00;
          end
          (!owner_req && !others): begin
            state_d    = IDLE;
            grant_d    = 8'h00;
            hold_cnt_d = 8'h00;
          end
          default: begin
            if (hold_cnt_q < HOLD_LIM) begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
      end
    endcase
  end

  // outputs come straight from the registers
  always_comb begin
    grant    = grant_q;
    grant_id = grant_id_q;
    busy     = |grant_q;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed scenarios plus randomized traffic checked
// against an owner/held-cycles reference model for three hold limits.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] g16, g4, g0;
  logic [2:0] i16, i4, i0;
  logic       b16, b4, b0;

  int n_tests = 0;
  int n_fail = 0;

  int m_owner [3];
  int m_ptr   [3];
  int m_held  [3];
  int m_lim   [3] = '{16, 4, 0};

  always #5 clk = ~clk;

  rr_arbiter8 u_dut16 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(g16), .grant_id(i16), .busy(b16)
  );

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(g4), .grant_id(i4), .busy(b4)
  );

  rr_arbiter8 #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(g0), .grant_id(i0), .busy(b0)
  );

  function automatic int search(logic [7:0] m, int p);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (p + k) % 8;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_ptr[i]   = 7;
      m_held[i]  = 0;
    end
  endtask

  task automatic model_step();
    logic [7:0] oth;
    int w;
    for (int i = 0; i < 3; i++) begin
      oth = req;
      if (m_owner[i] >= 0) oth[m_owner[i]] = 1'b0;
      w = search(oth, m_ptr[i]);
      if (m_owner[i] < 0) begin
        if (w >= 0) begin
          m_owner[i] = w; m_ptr[i] = w; m_held[i] = 1;
        end
      end else if (!req[m_owner[i]]) begin
        if (w >= 0) begin
          m_owner[i] = w; m_ptr[i] = w; m_held[i] = 1;
        end else begin
          m_owner[i] = -1;
        end
      end else if (m_lim[i] > 0 && m_held[i] >= m_lim[i] && w >= 0) begin
        m_owner[i] = w; m_ptr[i] = w; m_held[i] = 1;
      end else if (m_held[i] < 1000) begin
        m_held[i] = m_held[i] + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    req = r;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req = 8'hFF;
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    n_tests++;
    if (g16 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_grant: got %h want 00", g16);
    end
    n_tests++;
    if (b16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", b16);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (g16 !== 8'h01 || i16 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_first: got %h/%0d want 01/0", g16, i16);
    end
  endtask

  task automatic test_preempt();
    logic [7:0] exp;
    do_reset(8'h81);
    for (int c = 0; c < 20; c++) begin
      tick();
      exp = (((c / 4) % 2) == 0) ? 8'h01 : 8'h80;
      n_tests++;
      if (g4 !== exp) begin
        n_fail++;
        $display("FAIL preempt_c%0d: got %h want %h", c, g4, exp);
      end
    end
  endtask

  task automatic test_handoff();
    do_reset(8'h04);
    tick();
    req = 8'h24;
    repeat (3) begin
      tick();
      n_tests++;
      if (g16 !== 8'h04 || b16 !== 1'b1) begin
        n_fail++;
        $display("FAIL handoff_hold: got %h/%b want 04/1", g16, b16);
      end
    end
    req = 8'h20;
    tick();
    n_tests++;
    if (g16 !== 8'h20 || i16 !== 3'd5 || b16 !== 1'b1) begin
      n_fail++;
      $display("FAIL handoff: got %h/%0d/%b want 20/5/1",
               g16, i16, b16);
    end
  endtask

  task automatic test_wrap();
    do_reset(8'h40);
    tick();
    req = 8'h43;
    tick();
    n_tests++;
    if (g16 !== 8'h40) begin
      n_fail++;
      $display("FAIL wrap_own6: got %h want 40", g16);
    end
    req = 8'h03;
    tick();
    n_tests++;
    if (g16 !== 8'h01 || i16 !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_to0: got %h/%0d want 01/0", g16, i16);
    end
    req = 8'h02;
    tick();
    n_tests++;
    if (g16 !== 8'h02 || i16 !== 3'd1) begin
      n_fail++;
      $display("FAIL wrap_to1: got %h/%0d want 02/1", g16, i16);
    end
  endtask

  task automatic test_sole();
    do_reset(8'h08);
    for (int c = 0; c < 40; c++) begin
      tick();
      n_tests++;
      if (g16 !== 8'h08) begin
        n_fail++;
        $display("FAIL sole_c%0d: got %h want 08", c, g16);
      end
    end
    req = 8'h09;
    for (int c = 0; c < 30; c++) begin
      tick();
      n_tests++;
      if (g0 !== 8'h08) begin
        n_fail++;
        $display("FAIL nolimit_c%0d: got %h want 08", c, g0);
      end
    end
    req = 8'h01;
    tick();
    n_tests++;
    if (g0 !== 8'h01 || i0 !== 3'd0) begin
      n_fail++;
      $display("FAIL nolimit_rel: got %h/%0d want 01/0", g0, i0);
    end
  endtask

  task automatic test_async();
    do_reset(8'h10);
    tick();
    n_tests++;
    if (g16 !== 8'h10) begin
      n_fail++;
      $display("FAIL async_pre: got %h want 10", g16);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (g16 !== 8'h00 || b16 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got %h/%b want 00/0", g16, b16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (g16 !== 8'h10 || i16 !== 3'd4) begin
      n_fail++;
      $display("FAIL async_back: got %h/%0d want 10/4", g16, i16);
    end
  endtask

  task automatic test_random();
    logic [7:0] gv [3];
    logic [2:0] iv [3];
    logic       bv [3];
    logic [7:0] eg;
    do_reset(8'h00);
    for (int c = 0; c < 600; c++) begin
      req = req ^ 8'($urandom & $urandom);
      tick();
      gv[0] = g16; iv[0] = i16; bv[0] = b16;
      gv[1] = g4;  iv[1] = i4;  bv[1] = b4;
      gv[2] = g0;  iv[2] = i0;  bv[2] = b0;
      for (int i = 0; i < 3; i++) begin
        eg = (m_owner[i] < 0) ? 8'h00 : (8'h01 << m_owner[i]);
        n_tests++;
        if (gv[i] !== eg || bv[i] !== (m_owner[i] >= 0) ||
            (m_owner[i] >= 0 && iv[i] !== 3'(m_owner[i])) ||
            !$onehot0(gv[i])) begin
          n_fail++;
          $display("FAIL rand_c%0d_d%0d: got %h/%0d/%b want %h/%0d",
                   c, i, gv[i], iv[i], bv[i], eg, m_owner[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_preempt();
    test_handoff();
    test_wrap();
    test_sole();
    test_async();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
